uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Parametrised UART receive framer; next generation of the team's fixed 10-bit receive shift register.
- Shifts serial bits in on a sample strobe from the bit-timing logic.
- Detects the start bit, counts the frame, and extracts the data word.
- Checks stop bits and, optionally, parity; emits a one-cycle done pulse to the receive FIFO/control logic.

Parameters:
- DATA_W, 8, data bits per frame (5..9), sent LSB first.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- ODD_PARITY, 0, 1 = odd parity, 0 = even. Only used when UART_RX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sh  input  1  sample strobe, one clk wide, at bit centre; minimum spacing 3 clk
- sdi  input  1  synchronised serial line; idle = 1
- clr  input  1  synchronous abort
- sr  output  FRAME_W  raw frame shift register; sr[0] = start bit once complete
- data  output  DATA_W  last received data word
- done  output  1  one-cycle frame-complete pulse
- busy  output  1  frame in progress (SHIFT or CHECK)
- frm_err  output  1  stop-bit error for the last frame
- par_err  output  1  parity error for the last frame

Behaviour:
- Frame width: FRAME_W = 1 + DATA_W + PB + STOP_BITS, where PB = 1 if UART_RX_PARITY_EN is defined, else 0.
- Bit counter width: $clog2(FRAME_W+1).
- Reset (async, active-high), all outputs:
  - sr = all ones; data = 0; done = 0; busy = 0; frm_err = 0; par_err = 0.
  - State = IDLE; bit count = 0.
- Shift rule: sr <= {sdi, sr[FRAME_W-1:1]}, i.e. new bits enter at the MSB and move right.
- State IDLE:
  - sh with sdi=0: shift, count=1, go to SHIFT.
  - sh with sdi=1: ignored; sr unchanged, stays IDLE (line idle or glitch).
- State SHIFT:
  - Each sh shifts and increments count.
  - On the sh that makes count == FRAME_W, go to CHECK.
- State CHECK (exactly one clk):
  - data <= sr[DATA_W:1].
  - frm_err <= 1 if any of sr[FRAME_W-1 -: STOP_BITS] is 0.
  - par_err <= parity result (see Optional Feature).
  - done <= 1; go to IDLE with count = 0.
  - sh arriving in CHECK is dropped.
- Latency: done is high for exactly the one clk following the edge after the final sh edge.
- data, frm_err, par_err hold until the next done, clr, or reset.
- sr is not cleared on completion; it holds the full frame until the next start bit.
- busy = 1 in SHIFT and CHECK.
- clr:
  - Returns to IDLE, count = 0, sr = all ones.
  - Clears done, frm_err and par_err; data is held.
  - clr wins over a coincident sh.
- Reset mid-frame: immediate return to reset values; no done is generated.
- A start bit is not re-validated mid-frame. A 0 stop bit only sets frm_err; the frame still completes.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame carries a parity bit at sr[DATA_W+1].
  - par_err <= (^sr[DATA_W+1:1]) != ODD_PARITY.
- Undefined:
  - No parity bit; FRAME_W is one smaller.
  - par_err is tied 0; the port still exists so instantiations stay stable.

Decomposition:
- Shared package/include uart_defs:
  - State encodings IDLE=2'd0, SHIFT=2'd1, CHECK=2'd2.
  - FRAME_W computation (function/macro), used by uart_rx_frame and the future transmitter.
  - Default DATA_W/STOP_BITS constants.
- One sub-module: shift_reg_nbit.
  - Parameter W; ports clk, reset, clr, sh, sdi, sr.
  - Reset/clr value all ones; right-shifting.
  - Instantiated with W = FRAME_W.
- FSM, counter and checks live in uart_rx_frame.

Test Plan:
- Config: DATA_W=8, STOP_BITS=1, no macro. Bits 0,1,0,1,0,1,0,1,0,1 → data=0x55, sr=10'b1010101010, done for 1 clk, frm_err=0, busy falls after CHECK.
- Same config, 0xA3 with stop bit 0 → data=0xA3, frm_err=1, done pulses; next good frame 0x0F → frm_err=0.
- UART_RX_PARITY_EN, ODD_PARITY=0, data 0x07:
  - Parity bit 1 → par_err=0.
  - Parity bit 0 → par_err=1.
  - FRAME_W=11 in both cases.
- Idle glitch: three sh with sdi=1 in IDLE → busy=0, sr stays all ones, no done.
- Abort: 4 bits into a frame, assert clr together with sh → busy=0, sr all ones, no done; a full following frame 0x3C is received correctly.
- STOP_BITS=2, second stop bit 0 → frm_err=1. Async reset asserted mid-frame → all outputs return to reset values within the same cycle, no done.

Source files
------------

// File: rtl/uart_defs.sv
// Shared UART definitions: receive FSM states, frame-width helper and default frame shape.
// UART_RX_PARITY_EN adds one parity bit to every frame.
package uart_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_STOP_BITS = 1;

`ifdef UART_RX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Start bit + data + optional parity + stop bits.
  function automatic int unsigned frame_w(input int unsigned data_w,
                                          input int unsigned stop_bits,
                                          input int unsigned parity_bits);
    return 1 + data_w + parity_bits + stop_bits;
  endfunction

endpackage

// File: rtl/shift_reg_nbit.sv
// Right-shifting serial-in register; new bits enter at the MSB. Reset and clr load all ones.
module shift_reg_nbit #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         sh,
  input  logic         sdi,
  output logic [W-1:0] sr
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '1;
    end else if (sh) begin
      sr_d = {sdi, sr_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '1;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr = sr_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detect, frame count, data extraction, stop/parity checks, done pulse.
// Define UART_RX_PARITY_EN to receive and check a parity bit after the data bits.
module uart_rx_frame
  import uart_defs::*;
#(
  parameter int unsigned  DATA_W     = DEF_DATA_W,
  parameter int unsigned  STOP_BITS  = DEF_STOP_BITS,
  parameter int unsigned  ODD_PARITY = 0,
  localparam int unsigned FRAME_W    = frame_w(DATA_W, STOP_BITS, PARITY_BITS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sh,
  input  logic               sdi,
  input  logic               clr,
  output logic [FRAME_W-1:0] sr,
  output logic [DATA_W-1:0]  data,
  output logic               done,
  output logic               busy,
  output logic               frm_err,
  output logic               par_err
);

  localparam int unsigned      CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W);

  rx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               frm_err_q, frm_err_d;
  logic               par_err_q, par_err_d;
  logic               shift_en;
  logic               par_calc;

  // The register only moves on accepted strobes: idle-line strobes and strobes in CHECK are dropped.
  shift_reg_nbit #(
    .W (FRAME_W)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .sh    (shift_en),
    .sdi   (sdi),
    .sr    (sr)
  );

`ifdef UART_RX_PARITY_EN
  assign par_calc = (^sr[DATA_W+1:1]) != ODD_PARITY[0];
`else
  logic unused_odd_parity;
  assign unused_odd_parity = ODD_PARITY[0];
  assign par_calc          = 1'b0;
`endif

  always_comb begin
    shift_en  = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    done_d    = 1'b0;
    frm_err_d = frm_err_q;
    par_err_d = par_err_q;

    if (clr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      frm_err_d = 1'b0;
      par_err_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sh && !sdi) begin
            shift_en = 1'b1;
            cnt_d    = CNT_W'(1);
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (sh) begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_LAST) begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          data_d    = sr[DATA_W:1];
          frm_err_d = ~&sr[FRAME_W-1 -: STOP_BITS];
          par_err_d = par_calc;
          done_d    = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      frm_err_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      frm_err_q <= frm_err_d;
      par_err_q <= par_err_d;
    end
  end

  assign data    = data_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign frm_err = frm_err_q;
  assign par_err = par_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: two instances (8N1 even, 6-bit 2-stop odd), table + random frames.
module tb_uart_rx_frame;

`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int DW0 = 8;
  localparam int SB0 = 1;
  localparam int OD0 = 0;
  localparam int DW1 = 6;
  localparam int SB1 = 2;
  localparam int OD1 = 1;
  localparam int FW0 = 1 + DW0 + PB + SB0;
  localparam int FW1 = 1 + DW1 + PB + SB1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic sh0 = 1'b0, sdi0 = 1'b1, clr0 = 1'b0;
  logic sh1 = 1'b0, sdi1 = 1'b1, clr1 = 1'b0;

  logic [FW0-1:0] sr0;
  logic [DW0-1:0] data0;
  logic           done0, busy0, frm0, par0;
  logic [FW1-1:0] sr1;
  logic [DW1-1:0] data1;
  logic           done1, busy1, frm1, par1;

  int checks = 0;
  int errors = 0;
  int done_seen [2] = '{0, 0};
  int done_exp  [2] = '{0, 0};
  int cur = 0;

  logic [31:0] o_sr, o_data;
  logic        o_done, o_busy, o_frm, o_par;

  always #5 clk = ~clk;

  uart_rx_frame #(.DATA_W(DW0), .STOP_BITS(SB0), .ODD_PARITY(OD0)) dut0 (
    .clk(clk), .reset(reset), .sh(sh0), .sdi(sdi0), .clr(clr0),
    .sr(sr0), .data(data0), .done(done0), .busy(busy0), .frm_err(frm0), .par_err(par0)
  );

  uart_rx_frame #(.DATA_W(DW1), .STOP_BITS(SB1), .ODD_PARITY(OD1)) dut1 (
    .clk(clk), .reset(reset), .sh(sh1), .sdi(sdi1), .clr(clr1),
    .sr(sr1), .data(data1), .done(done1), .busy(busy1), .frm_err(frm1), .par_err(par1)
  );

  always @(negedge clk) begin
    if (done0) done_seen[0]++;
    if (done1) done_seen[1]++;
  end

  always_comb begin
    if (cur == 0) begin
      o_sr = 32'(sr0); o_data = 32'(data0);
      o_done = done0; o_busy = busy0; o_frm = frm0; o_par = par0;
    end else begin
      o_sr = 32'(sr1); o_data = 32'(data1);
      o_done = done1; o_busy = busy1; o_frm = frm1; o_par = par1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int inst, input logic s, input logic d, input logic c);
    if (inst == 0) begin sh0 = s; sdi0 = d; clr0 = c; end
    else begin sh1 = s; sdi1 = d; clr1 = c; end
  endtask

  // Drive one strobe for a single clock; returns 1ns after the sampling edge.
  task automatic pulse(input int inst, input logic d, input logic c);
    drive(inst, 1'b1, d, c);
    @(posedge clk); #1;
    drive(inst, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] ones(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  task automatic send_frame(input int inst, input logic [8:0] d, input logic [1:0] stop,
                            input logic bad_par, input logic exp_frm);
    int dw, sb, od, fw, n;
    logic [15:0] bits;
    logic [31:0] exp_data;
    logic        p;
    dw = (inst == 0) ? DW0 : DW1;
    sb = (inst == 0) ? SB0 : SB1;
    od = (inst == 0) ? OD0 : OD1;
    fw = (inst == 0) ? FW0 : FW1;
    exp_data = 32'(d) & ones(dw);
    p = 1'((($countones(exp_data) + od) % 2)) ^ bad_par;
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < dw; i++) begin bits[n] = exp_data[i]; n++; end
    if (PB == 1) begin bits[n] = p; n++; end
    for (int i = 0; i < sb; i++) begin bits[n] = stop[i]; n++; end
    cur = inst;
    for (int i = 0; i < n; i++) begin
      pulse(inst, bits[i], 1'b0);
      if (i == n / 2) begin
        chk("busy_mid_frame", 32'(o_busy), 32'd1);
        chk("done_mid_frame", 32'(o_done), 32'd0);
      end
      if (i != n - 1) idle(2);
    end
    chk("done_before_check", 32'(o_done), 32'd0);
    chk("busy_in_check", 32'(o_busy), 32'd1);
    idle(1);
    done_exp[inst]++;
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("busy_after_check", 32'(o_busy), 32'd0);
    chk("data", o_data, exp_data);
    chk("frm_err", 32'(o_frm), 32'(exp_frm));
    chk("par_err", 32'(o_par), (PB == 1) ? 32'(bad_par) : 32'd0);
    chk("sr_frame", o_sr, 32'(bits) & ones(fw));
    idle(1);
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("data_hold", o_data, exp_data);
  endtask

  typedef struct {
    int         inst;
    logic [8:0] d;
    logic [1:0] stop;
    logic       bad_par;
    logic       exp_frm;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{0, 9'h055, 2'b01, 1'b0, 1'b0};
    tbl[1] = '{0, 9'h0A3, 2'b00, 1'b0, 1'b1};
    tbl[2] = '{0, 9'h00F, 2'b01, 1'b0, 1'b0};
    tbl[3] = '{0, 9'h007, 2'b01, 1'b1, 1'b0};
    tbl[4] = '{1, 9'h02A, 2'b11, 1'b0, 1'b0};
    tbl[5] = '{1, 9'h015, 2'b01, 1'b1, 1'b1};
    tbl[6] = '{1, 9'h03F, 2'b10, 1'b0, 1'b1};

    // Reset values.
    #12;
    cur = 0;
    chk("rst_sr", o_sr, ones(FW0));
    chk("rst_data", o_data, 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_frm", 32'(o_frm), 32'd0);
    chk("rst_par", 32'(o_par), 32'd0);
    reset = 1'b0;
    idle(2);

    foreach (tbl[i]) send_frame(tbl[i].inst, tbl[i].d, tbl[i].stop, tbl[i].bad_par, tbl[i].exp_frm);

    // clr clears the error flags but holds the data word.
    send_frame(0, 9'h0A3, 2'b00, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b1, 1'b1);
    idle(1);
    drive(0, 1'b0, 1'b1, 1'b0);
    chk("clr_frm", 32'(o_frm), 32'd0);
    chk("clr_data_hold", o_data, 32'h0A3);
    chk("clr_done", 32'(o_done), 32'd0);
    idle(2);

    // Idle-line strobes are ignored.
    cur = 0;
    for (int i = 0; i < 3; i++) begin
      pulse(0, 1'b1, 1'b0);
      chk("glitch_busy", 32'(o_busy), 32'd0);
      idle(2);
    end
    chk("glitch_sr", o_sr, ones(FW0));

    // Abort four bits in with clr coincident with a strobe.
    pulse(0, 1'b0, 1'b0); idle(2);
    pulse(0, 1'b1, 1'b0); idle(2);
    pulse(0, 1'b0, 1'b0); idle(2);
    pulse(0, 1'b1, 1'b0); idle(2);
    chk("abort_busy_before", 32'(o_busy), 32'd1);
    pulse(0, 1'b0, 1'b1);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_sr", o_sr, ones(FW0));
    idle(2);
    send_frame(0, 9'h03C, 2'b01, 1'b0, 1'b0);

    for (int r = 0; r < 16; r++) begin
      int         inst;
      logic [8:0] d;
      logic [1:0] stop;
      logic       bad, ef;
      inst = int'($urandom_range(0, 1));
      d    = 9'($urandom);
      stop = 2'($urandom);
      bad  = 1'($urandom);
      ef   = (inst == 0) ? !stop[0] : !(stop[0] && stop[1]);
      send_frame(inst, d, stop, bad, ef);
      idle(int'($urandom_range(0, 3)));
    end

    // Frame with errors on inst0 then asynchronous reset mid-frame.
    send_frame(0, 9'h0C6, 2'b00, 1'b0, 1'b1);
    cur = 0;
    pulse(0, 1'b0, 1'b0); idle(2);
    pulse(0, 1'b1, 1'b0); idle(1);
    #2 reset = 1'b1;
    #1;
    chk("arst_sr", o_sr, ones(FW0));
    chk("arst_data", o_data, 32'd0);
    chk("arst_done", 32'(o_done), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_frm", 32'(o_frm), 32'd0);
    chk("arst_par", 32'(o_par), 32'd0);
    #2 reset = 1'b0;
    idle(6);
    chk("arst_no_resume", 32'(o_busy), 32'd0);

    chk("done_count0", 32'(done_seen[0]), 32'(done_exp[0]));
    chk("done_count1", 32'(done_seen[1]), 32'(done_exp[1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
